// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Moore instruction sequencer for the datapath (fetch, decode, ALU and halt).
// Optional multiply/divide sequencing is enabled by defining MULDIV_EN.
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR_Data,
    input  logic        mem_ready,
    input  logic        Stop,
    output logic        Run,
    output logic        PC_out,
    output logic        PC_in,
    output logic        IncPC,
    output logic        MAR_in,
    output logic        MDR_in,
    output logic        MDR_out,
    output logic        Read,
    output logic        IR_in,
    output logic        Y_in,
    output logic        Z_in,
    output logic        Zlow_out,
    output logic        Zhigh_out,
    output logic        LO_in,
    output logic        HI_in,
    output logic [15:0] R_out,
    output logic [15:0] R_in,
    output logic [4:0]  alu_instruction,
    output logic [3:0]  state_dbg
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    localparam logic [4:0] OP_HALT = 5'b11011;

    logic [3:0] state_q, state_d;
    logic       armed_q;
    logic       t1_wait_q;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_muldiv, is_halt;
    logic [3:0] boundary;
    logic       unused_ir;

    assign op        = IR_Data[31:27];
    assign ra        = IR_Data[26:23];
    assign rb        = IR_Data[22:19];
    assign rc        = IR_Data[18:15];
    assign unused_ir = ^IR_Data[14:0];

    assign is_alu  = (op >= 5'd3) && (op <= 5'd13);
    assign is_halt = (op == OP_HALT);
`ifdef MULDIV_EN
    assign is_muldiv = (op == 5'd14) || (op == 5'd15);
`else
    assign is_muldiv = 1'b0;
`endif

    // Every instruction end funnels through here so Stop only acts at a boundary.
    assign boundary = Stop ? S_IDLE : S_T0;

    function automatic logic [15:0] reg_sel(input logic [3:0] idx);
        return 16'b1 << idx;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = (armed_q && !Stop) ? S_T0 : S_IDLE;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = mem_ready ? S_T2 : S_T1;
            S_T2:    state_d = is_halt ? S_HALT : ((is_alu || is_muldiv) ? S_T3 : boundary);
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = is_muldiv ? S_T6 : boundary;
            S_T6:    state_d = boundary;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // armed_q keeps the first edge after reset release in IDLE.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b0;
            t1_wait_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= 1'b1;
            t1_wait_q <= (state_q == S_T1) && (state_d == S_T1);
        end
    end

    always_comb begin
        Run             = 1'b0;
        PC_out          = 1'b0;
        PC_in           = 1'b0;
        IncPC           = 1'b0;
        MAR_in          = 1'b0;
        MDR_in          = 1'b0;
        MDR_out         = 1'b0;
        Read            = 1'b0;
        IR_in           = 1'b0;
        Y_in            = 1'b0;
        Z_in            = 1'b0;
        Zlow_out        = 1'b0;
        Zhigh_out       = 1'b0;
        LO_in           = 1'b0;
        HI_in           = 1'b0;
        R_out           = 16'h0;
        R_in            = 16'h0;
        alu_instruction = 5'h0;
        // Gating on clr forces everything low the moment reset asserts.
        if (clr) begin
            Run = (state_q != S_HALT);
            case (state_q)
                S_T0: begin
                    PC_out = 1'b1;
                    MAR_in = 1'b1;
                    IncPC  = 1'b1;
                    Z_in   = 1'b1;
                end
                S_T1: begin
                    Zlow_out = 1'b1;
                    PC_in    = !t1_wait_q;
                    Read     = 1'b1;
                    MDR_in   = 1'b1;
                end
                S_T2: begin
                    MDR_out = 1'b1;
                    IR_in   = 1'b1;
                end
                S_T3: begin
                    Y_in  = 1'b1;
                    R_out = is_muldiv ? reg_sel(ra) : reg_sel(rb);
                end
                S_T4: begin
                    Z_in            = 1'b1;
                    R_out           = is_muldiv ? reg_sel(rb) : reg_sel(rc);
                    alu_instruction = op;
                end
                S_T5: begin
                    Zlow_out = 1'b1;
`ifdef MULDIV_EN
                    if (is_muldiv) LO_in = 1'b1;
                    else R_in = reg_sel(ra);
`else
                    R_in = reg_sel(ra);
`endif
                end
                S_T6: begin
`ifdef MULDIV_EN
                    Zhigh_out = 1'b1;
                    HI_in     = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign state_dbg = state_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized instruction-level checking of control_sequencer.
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] IR_Data = 32'h0;
    logic        mem_ready = 1'b0;
    logic        Stop = 1'b0;
    logic        Run, PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, Read, IR_in;
    logic        Y_in, Z_in, Zlow_out, Zhigh_out, LO_in, HI_in;
    logic [15:0] R_out, R_in;
    logic [4:0]  alu_instruction;
    logic [3:0]  state_dbg;
    logic [14:0] ctl_vec;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [14:0] C_RUN  = 15'd1 << 14;
    localparam logic [14:0] C_PCO  = 15'd1 << 13;
    localparam logic [14:0] C_PCI  = 15'd1 << 12;
    localparam logic [14:0] C_INC  = 15'd1 << 11;
    localparam logic [14:0] C_MAR  = 15'd1 << 10;
    localparam logic [14:0] C_MDRI = 15'd1 << 9;
    localparam logic [14:0] C_MDRO = 15'd1 << 8;
    localparam logic [14:0] C_READ = 15'd1 << 7;
    localparam logic [14:0] C_IRIN = 15'd1 << 6;
    localparam logic [14:0] C_YIN  = 15'd1 << 5;
    localparam logic [14:0] C_ZIN  = 15'd1 << 4;
    localparam logic [14:0] C_ZLO  = 15'd1 << 3;
    localparam logic [14:0] C_ZHI  = 15'd1 << 2;
    localparam logic [14:0] C_LOI  = 15'd1 << 1;
    localparam logic [14:0] C_HII  = 15'd1 << 0;

    // State numbering observed on state_dbg: IDLE, T0..T6, HALT.
    localparam logic [3:0] E_IDLE = 4'd0, E_T0 = 4'd1, E_T1 = 4'd2, E_T2 = 4'd3;
    localparam logic [3:0] E_T3 = 4'd4, E_T4 = 4'd5, E_T5 = 4'd6, E_T6 = 4'd7, E_HALT = 4'd8;

    control_sequencer dut (
        .clk(clk), .clr(clr), .IR_Data(IR_Data), .mem_ready(mem_ready), .Stop(Stop),
        .Run(Run), .PC_out(PC_out), .PC_in(PC_in), .IncPC(IncPC), .MAR_in(MAR_in),
        .MDR_in(MDR_in), .MDR_out(MDR_out), .Read(Read), .IR_in(IR_in), .Y_in(Y_in),
        .Z_in(Z_in), .Zlow_out(Zlow_out), .Zhigh_out(Zhigh_out), .LO_in(LO_in), .HI_in(HI_in),
        .R_out(R_out), .R_in(R_in), .alu_instruction(alu_instruction), .state_dbg(state_dbg)
    );

    assign ctl_vec = {Run, PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, Read, IR_in,
                      Y_in, Z_in, Zlow_out, Zhigh_out, LO_in, HI_in};

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] oh(input logic [3:0] i);
        logic [15:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check_all(input logic [14:0] c, input logic [15:0] ro, input logic [15:0] ri,
                             input logic [4:0] al, input logic [3:0] st);
        chk_eq("ctl", {17'h0, ctl_vec}, {17'h0, c});
        chk_eq("r_out", {16'h0, R_out}, {16'h0, ro});
        chk_eq("r_in", {16'h0, R_in}, {16'h0, ri});
        chk_eq("alu", {27'h0, alu_instruction}, {27'h0, al});
        chk_eq("state", {28'h0, state_dbg}, {28'h0, st});
    endtask

    // One clock period: drive inputs at the falling edge, check, then pass the rising edge.
    task automatic cyc(input logic [14:0] c, input logic [15:0] ro, input logic [15:0] ri,
                       input logic [4:0] al, input logic [3:0] st, input logic mr, input logic sp);
        @(negedge clk);
        mem_ready = mr;
        Stop = sp;
        #1;
        check_all(c, ro, ri, al, st);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb1();
        return 1'($urandom_range(0, 1));
    endfunction

    // Assert reset (if not already), hold, release; expect two IDLE cycles then T0 follows.
    task automatic do_reset();
        clr = 1'b0;
        #1;
        check_all(15'h0, 16'h0, 16'h0, 5'h0, E_IDLE);
        cyc(15'h0, 16'h0, 16'h0, 5'h0, E_IDLE, rb1(), rb1());
        clr = 1'b1;
        cyc(C_RUN, 16'h0, 16'h0, 5'h0, E_IDLE, rb1(), 1'b0);
        cyc(C_RUN, 16'h0, 16'h0, 5'h0, E_IDLE, rb1(), 1'b0);
    endtask

    // Expected trace of one instruction, built from its opcode class.
    // Returns 1 when the instruction halted the sequencer.
    task automatic run_instr(input logic [31:0] ir, input int waits, input logic stop_end,
                             input int idle_hold, output logic halted);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        int cls;
        IR_Data = ir;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        cls = 0;
        if (op >= 5'd3 && op <= 5'd13) cls = 1;
`ifdef MULDIV_EN
        if (op == 5'd14 || op == 5'd15) cls = 2;
`endif
        if (op == 5'd27) cls = 3;
        halted = (cls == 3);
        cyc(C_RUN | C_PCO | C_MAR | C_INC | C_ZIN, 16'h0, 16'h0, 5'h0, E_T0, rb1(), rb1());
        for (int i = 0; i <= waits; i++)
            cyc(C_RUN | C_ZLO | C_READ | C_MDRI | ((i == 0) ? C_PCI : 15'h0),
                16'h0, 16'h0, 5'h0, E_T1, (i == waits), rb1());
        cyc(C_RUN | C_MDRO | C_IRIN, 16'h0, 16'h0, 5'h0, E_T2, rb1(), (cls == 0) ? stop_end : rb1());
        if (cls == 1) begin
            cyc(C_RUN | C_YIN, oh(rb), 16'h0, 5'h0, E_T3, rb1(), rb1());
            cyc(C_RUN | C_ZIN, oh(rc), 16'h0, op, E_T4, rb1(), rb1());
            cyc(C_RUN | C_ZLO, 16'h0, oh(ra), 5'h0, E_T5, rb1(), stop_end);
        end else if (cls == 2) begin
            cyc(C_RUN | C_YIN, oh(ra), 16'h0, 5'h0, E_T3, rb1(), rb1());
            cyc(C_RUN | C_ZIN, oh(rb), 16'h0, op, E_T4, rb1(), rb1());
            cyc(C_RUN | C_ZLO | C_LOI, 16'h0, 16'h0, 5'h0, E_T5, rb1(), rb1());
            cyc(C_RUN | C_ZHI | C_HII, 16'h0, 16'h0, 5'h0, E_T6, rb1(), stop_end);
        end else if (cls == 3) begin
            repeat (3) cyc(15'h0, 16'h0, 16'h0, 5'h0, E_HALT, rb1(), rb1());
        end
        if (stop_end && cls != 3) begin
            repeat (idle_hold) cyc(C_RUN, 16'h0, 16'h0, 5'h0, E_IDLE, rb1(), 1'b1);
            cyc(C_RUN, 16'h0, 16'h0, 5'h0, E_IDLE, rb1(), 1'b0);
        end
    endtask

    function automatic logic [4:0] pick_op();
        int r;
        r = $urandom_range(0, 19);
        if (r < 9) return 5'($urandom_range(3, 13));
        if (r < 11) return 5'd26;
        if (r < 13) return 5'($urandom_range(0, 2));
        if (r < 15) return 5'($urandom_range(16, 25));
        if (r < 16) return 5'($urandom_range(28, 31));
        if (r < 19) return 5'($urandom_range(14, 15));
        return 5'd27;
    endfunction

    initial begin
        logic h;
        logic [31:0] ir;
        #2;
        check_all(15'h0, 16'h0, 16'h0, 5'h0, E_IDLE);
        @(posedge clk);
        #1;
        do_reset();

        run_instr(32'h53320000, 0, 1'b0, 0, h);
        run_instr(32'h53320000, 3, 1'b0, 0, h);
        run_instr(32'h70A00000, 0, 1'b0, 0, h);
        run_instr(32'hD0000000, 1, 1'b0, 0, h);
        run_instr(32'h53320000, 0, 1'b1, 2, h);
        run_instr(32'h53320000, 0, 1'b1, 0, h);
        run_instr(32'hD8000000, 0, 1'b0, 0, h);
        do_reset();

        // Reset striking mid-T4 must clear outputs without a clock edge.
        IR_Data = 32'h53320000;
        cyc(C_RUN | C_PCO | C_MAR | C_INC | C_ZIN, 16'h0, 16'h0, 5'h0, E_T0, 1'b0, 1'b0);
        cyc(C_RUN | C_ZLO | C_READ | C_MDRI | C_PCI, 16'h0, 16'h0, 5'h0, E_T1, 1'b1, 1'b0);
        cyc(C_RUN | C_MDRO | C_IRIN, 16'h0, 16'h0, 5'h0, E_T2, 1'b0, 1'b0);
        cyc(C_RUN | C_YIN, 16'h0040, 16'h0, 5'h0, E_T3, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_all(C_RUN | C_ZIN, 16'h0010, 16'h0, 5'b01010, E_T4);
        do_reset();

        // Reset during a T1 wait.
        cyc(C_RUN | C_PCO | C_MAR | C_INC | C_ZIN, 16'h0, 16'h0, 5'h0, E_T0, 1'b0, 1'b0);
        cyc(C_RUN | C_ZLO | C_READ | C_MDRI | C_PCI, 16'h0, 16'h0, 5'h0, E_T1, 1'b0, 1'b0);
        do_reset();

        for (int n = 0; n < 150; n++) begin
            ir = $urandom;
            ir[31:27] = pick_op();
            run_instr(ir, $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 2), h);
            if (h) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end
endmodule
